// File: rtl/axis_pkt_packer.sv
// AXI-Stream packet packer: folds each packet into one wide {payload, byte count, tag} word held in a show-ahead FIFO.
// Build option PKT_USER_EN: tag = ruser[7:0] of the first beat; when undefined the tag is 8'h00 and ruser is ignored.
module axis_pkt_packer #(
    parameter int DATA_W    = 256,
    parameter int USER_W    = 128,
    parameter int MAX_BEATS = 4,
    parameter int DEPTH     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              rdata,
    input  logic [DATA_W/8-1:0]            rkeep,
    input  logic [USER_W-1:0]              ruser,
    input  logic                           rvalid,
    output logic                           rready,
    input  logic                           rlast,
    output logic [MAX_BEATS*DATA_W+23:0]   pkt_data,
    output logic                           pkt_empty,
    input  logic                           pkt_re,
    output logic [$clog2(DEPTH):0]         pkt_count,
    output logic [15:0]                    drop_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int BUF_W  = MAX_BEATS * DATA_W;
    localparam int PKT_W  = BUF_W + 24;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [15:0]      bytes_q, bytes_d;
    logic [7:0]       tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic        full;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] beat_bytes;
    logic [15:0] drop_inc;
    logic [7:0]  first_tag;
    logic        unused_user;

    function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + 16'(k[i]);
        end
        return n;
    endfunction

`ifdef PKT_USER_EN
    assign first_tag = ruser[7:0];
`else
    assign first_tag = 8'h00;
`endif
    assign unused_user = ^ruser;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign accept     = rvalid && rready;
    assign beat_bytes = popcount(rkeep);
    assign drop_inc   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

    // Handshake: a beat transfers on any rising edge where rvalid && rready; rready never depends on rvalid.
    always_comb begin
        rready = 1'b0;
        case (state_q)
            S_IDLE:    rready = !full;
            S_COLLECT: rready = 1'b1;
            S_DROP:    rready = 1'b1;
            S_COMMIT:  rready = 1'b0;
            default:   rready = 1'b0;
        endcase
        if (rst) begin
            rready = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        bytes_d = bytes_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Clearing the whole buffer here guarantees no residue from an earlier dropped packet.
                    buf_d               = '0;
                    buf_d[DATA_W-1:0]   = rdata;
                    bytes_d             = beat_bytes;
                    tag_d               = first_tag;
                    idx_d               = IDX_W'(1);
                    state_d             = rlast ? S_COMMIT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (idx_q == IDX_W'(MAX_BEATS)) begin
                        buf_d   = '0;
                        bytes_d = '0;
                        idx_d   = '0;
                        if (rlast) begin
                            drop_d  = drop_inc;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        buf_d[idx_q*DATA_W +: DATA_W] = rdata;
                        bytes_d = bytes_q + beat_bytes;
                        idx_d   = idx_q + IDX_W'(1);
                        if (rlast) begin
                            state_d = S_COMMIT;
                        end
                    end
                end
            end
            S_DROP: begin
                if (accept && rlast) begin
                    drop_d  = drop_inc;
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                wr_en   = 1'b1;
                buf_d   = '0;
                bytes_d = '0;
                tag_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = pkt_re && (count_q != '0);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            bytes_q  <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            bytes_q  <= bytes_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pkt_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {buf_q, bytes_q, tag_q};
        end
    end

    assign pkt_empty = (count_q == '0);
    assign pkt_data  = pkt_empty ? '0 : mem_q[rd_ptr_q];
    assign pkt_count = count_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_axis_pkt_packer.sv
// Directed bench for axis_pkt_packer: hand-computed packet words checked through an expected-word queue.
// Define PKT_USER_EN for both the bench and the design to exercise the ruser tag path.
module tb_axis_pkt_packer;
    localparam int DATA_W    = 256;
    localparam int USER_W    = 128;
    localparam int MAX_BEATS = 4;
    localparam int DEPTH     = 16;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int PKT_W     = MAX_BEATS * DATA_W + 24;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] rdata = '0;
    logic [KEEP_W-1:0] rkeep = '0;
    logic [USER_W-1:0] ruser = '0;
    logic              rvalid = 1'b0;
    logic              rready;
    logic              rlast = 1'b0;
    logic [PKT_W-1:0]  pkt_data;
    logic              pkt_empty;
    logic              pkt_re = 1'b0;
    logic [CNT_W-1:0]  pkt_count;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PKT_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] d0, d1, d2, d3;

    always #5 clk = ~clk;

    axis_pkt_packer #(
        .DATA_W(DATA_W), .USER_W(USER_W), .MAX_BEATS(MAX_BEATS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rkeep(rkeep), .ruser(ruser),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .pkt_data(pkt_data),
        .pkt_empty(pkt_empty), .pkt_re(pkt_re), .pkt_count(pkt_count), .drop_cnt(drop_cnt)
    );

    function automatic logic [7:0] exp_tag(input logic [7:0] u);
`ifdef PKT_USER_EN
        return u;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] beat_data(input int p, input int b);
        return {8{8'(p), 8'(b), 16'hC0DE}};
    endfunction

    function automatic logic [PKT_W-1:0] make_word(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1,
                                                   input logic [DATA_W-1:0] s2, input logic [DATA_W-1:0] s3,
                                                   input logic [15:0] bytes, input logic [7:0] tag);
        return {s3, s2, s1, s0, bytes, tag};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] data, input logic [KEEP_W-1:0] keep,
                             input logic [7:0] user, input logic last);
        int n;
        rdata  = data;
        rkeep  = keep;
        ruser  = USER_W'(user);
        rlast  = last;
        rvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat_rready", DATA_W'(rready), DATA_W'(1));
        to_drive();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [PKT_W-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        @(negedge clk);
        check({name, "_empty"}, DATA_W'(pkt_empty), DATA_W'(0));
        check({name, "_tag"}, DATA_W'(pkt_data[7:0]), DATA_W'(e[7:0]));
        check({name, "_bytes"}, DATA_W'(pkt_data[23:8]), DATA_W'(e[23:8]));
        for (int s = 0; s < MAX_BEATS; s++) begin
            check($sformatf("%s_slot%0d", name, s), pkt_data[24 + s*DATA_W +: DATA_W], e[24 + s*DATA_W +: DATA_W]);
        end
        pkt_re = 1'b1;
        to_drive();
        pkt_re = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rready", DATA_W'(rready), DATA_W'(0));
        check("rst_empty", DATA_W'(pkt_empty), DATA_W'(1));
        check("rst_count", DATA_W'(pkt_count), DATA_W'(0));
        check("rst_drop", DATA_W'(drop_cnt), DATA_W'(0));
        check("rst_data", pkt_data[DATA_W-1:0], DATA_W'(0));
        to_drive();
        rst = 1'b0;

        // single beat, 16 bytes
        d0 = {32{8'hA5}};
        send_beat(d0, 32'h0000_FFFF, 8'h11, 1'b1);
        exp_q.push_back(make_word(d0, '0, '0, '0, 16'd16, exp_tag(8'h11)));
        @(negedge clk);
        check("t1_empty_commit", DATA_W'(pkt_empty), DATA_W'(1));
        check("t1_rready_commit", DATA_W'(rready), DATA_W'(0));
        @(negedge clk);
        check("t1_empty_after", DATA_W'(pkt_empty), DATA_W'(0));
        check("t1_count", DATA_W'(pkt_count), DATA_W'(1));
        pop_check("t1");
        @(negedge clk);
        check("t1_count_pop", DATA_W'(pkt_count), DATA_W'(0));
        to_drive();

        // four full beats
        for (int b = 0; b < 4; b++) send_beat(beat_data(2, b), KEEP_ALL, 8'h22 + 8'(b), (b == 3));
        exp_q.push_back(make_word(beat_data(2, 0), beat_data(2, 1), beat_data(2, 2), beat_data(2, 3),
                                  16'd128, exp_tag(8'h22)));
        to_drive();
        @(negedge clk);
        check("t2_count", DATA_W'(pkt_count), DATA_W'(1));
        pop_check("t2");
        @(negedge clk);
        check("t2_empty_pop", DATA_W'(pkt_empty), DATA_W'(1));
        check("t2_count_pop", DATA_W'(pkt_count), DATA_W'(0));
        to_drive();

        // five-beat oversize packet dropped on its last beat
        for (int b = 0; b < 5; b++) send_beat(beat_data(3, b), KEEP_ALL, 8'h30, (b == 4));
        @(negedge clk);
        check("t3_drop1", DATA_W'(drop_cnt), DATA_W'(1));
        check("t3_count1", DATA_W'(pkt_count), DATA_W'(0));
        check("t3_rready1", DATA_W'(rready), DATA_W'(1));
        to_drive();
        // six-beat packet passes through the discard state
        for (int b = 0; b < 5; b++) send_beat(beat_data(3, 10 + b), KEEP_ALL, 8'h31, 1'b0);
        @(negedge clk);
        check("t3_rready_drop", DATA_W'(rready), DATA_W'(1));
        check("t3_drop_pending", DATA_W'(drop_cnt), DATA_W'(1));
        to_drive();
        send_beat(beat_data(3, 15), KEEP_ALL, 8'h31, 1'b1);
        @(negedge clk);
        check("t3_drop2", DATA_W'(drop_cnt), DATA_W'(2));
        check("t3_count2", DATA_W'(pkt_count), DATA_W'(0));
        to_drive();
        send_beat(beat_data(3, 9), 32'h0000_0007, 8'h33, 1'b1);
        exp_q.push_back(make_word(beat_data(3, 9), '0, '0, '0, 16'd3, exp_tag(8'h33)));
        to_drive();
        @(negedge clk);
        check("t3_count_after", DATA_W'(pkt_count), DATA_W'(1));
        pop_check("t3");

        // fill the FIFO
        for (int p = 0; p < 16; p++) begin
            send_beat(beat_data(4, p), KEEP_W'((64'd1 << (p + 1)) - 64'd1), 8'h40 + 8'(p), 1'b1);
            exp_q.push_back(make_word(beat_data(4, p), '0, '0, '0, 16'(p + 1), exp_tag(8'h40 + 8'(p))));
        end
        to_drive();
        @(negedge clk);
        check("t4_count_full", DATA_W'(pkt_count), DATA_W'(16));
        check("t4_rready_full", DATA_W'(rready), DATA_W'(0));
        to_drive();
        rdata = beat_data(4, 16); rkeep = KEEP_ALL; ruser = USER_W'(8'h50); rlast = 1'b1; rvalid = 1'b1;
        @(negedge clk);
        check("t4_rready_hold", DATA_W'(rready), DATA_W'(0));
        pop_check("t4_pop");
        @(negedge clk);
        check("t4_rready_free", DATA_W'(rready), DATA_W'(1));
        check("t4_count_15", DATA_W'(pkt_count), DATA_W'(15));
        to_drive();
        rvalid = 1'b0; rlast = 1'b0;
        exp_q.push_back(make_word(beat_data(4, 16), '0, '0, '0, 16'd32, exp_tag(8'h50)));
        to_drive();
        @(negedge clk);
        check("t4_count_refull", DATA_W'(pkt_count), DATA_W'(16));
        for (int p = 0; p < 16; p++) pop_check($sformatf("t4_drain%0d", p));
        @(negedge clk);
        check("t4_empty_drained", DATA_W'(pkt_empty), DATA_W'(1));
        to_drive();

        // commit and pop on the same edge
        for (int p = 0; p < 3; p++) begin
            send_beat(beat_data(5, p), KEEP_ALL, 8'h60 + 8'(p), 1'b1);
            exp_q.push_back(make_word(beat_data(5, p), '0, '0, '0, 16'd32, exp_tag(8'h60 + 8'(p))));
        end
        to_drive();
        @(negedge clk);
        check("t5_count3", DATA_W'(pkt_count), DATA_W'(3));
        to_drive();
        send_beat(beat_data(5, 3), 32'h0000_0003, 8'h63, 1'b1);
        exp_q.push_back(make_word(beat_data(5, 3), '0, '0, '0, 16'd2, exp_tag(8'h63)));
        pop_check("t5_pop");
        @(negedge clk);
        check("t5_count_keep", DATA_W'(pkt_count), DATA_W'(3));
        for (int p = 0; p < 3; p++) pop_check($sformatf("t5_drain%0d", p));
        @(negedge clk);
        check("t5_count_zero", DATA_W'(pkt_count), DATA_W'(0));
        to_drive();

        // reset in the middle of a packet
        send_beat(beat_data(6, 9), KEEP_ALL, 8'h70, 1'b1);
        to_drive();
        send_beat(beat_data(6, 0), KEEP_ALL, 8'h5C, 1'b0);
        rdata = beat_data(6, 1); rkeep = KEEP_ALL; ruser = USER_W'(8'hAA); rlast = 1'b0; rvalid = 1'b1;
        rst = 1'b1;
        to_drive();
        @(negedge clk);
        check("t6_rready", DATA_W'(rready), DATA_W'(0));
        check("t6_empty", DATA_W'(pkt_empty), DATA_W'(1));
        check("t6_count", DATA_W'(pkt_count), DATA_W'(0));
        check("t6_drop", DATA_W'(drop_cnt), DATA_W'(0));
        check("t6_data", pkt_data[DATA_W+23:24], DATA_W'(0));
        to_drive();
        rst = 1'b0; rvalid = 1'b0;
        exp_q.delete();
        send_beat(beat_data(7, 0), KEEP_ALL, 8'h5C, 1'b0);
        send_beat(beat_data(7, 1), 32'h0000_00FF, 8'hAA, 1'b1);
        exp_q.push_back(make_word(beat_data(7, 0), beat_data(7, 1), '0, '0, 16'd40, exp_tag(8'h5C)));
        to_drive();
        @(negedge clk);
        check("t6_count_after", DATA_W'(pkt_count), DATA_W'(1));
        pop_check("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
